// File: rtl/alu_exec_stage.sv
// Single-issue execute stage: register file, operand capture with forwarding from EX,
// external ALU handshake, writeback report and a RUN/HALT control state.
module alu_exec_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] instr,
   output logic [4:0]  alu_op,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   input  logic [15:0] alu_result,
   output logic        wb_valid,
   output logic [5:0]  wb_dest,
   output logic [15:0] wb_data,
   input  logic        dbg_we,
   input  logic [5:0]  dbg_addr,
   input  logic [15:0] dbg_wdata,
   output logic [15:0] dbg_rdata,
   output logic        halted,
   output logic [15:0] retired
);

   localparam int unsigned DW   = 16;
   localparam int unsigned AW   = 6;
   localparam int unsigned OPW  = 4;
   localparam int unsigned NREG = 64;
   localparam logic [OPW-1:0] OP_LAST_WR = 4'hB;
   localparam logic [OPW-1:0] OP_HALT    = 4'hF;

   typedef enum logic {ST_RUN, ST_HALT} state_e;

   state_e           state_q, state_d;
   logic             ex_valid_q, ex_valid_d;
   logic [OPW-1:0]   ex_op_q, ex_op_d;
   logic [AW-1:0]    ex_dest_q, ex_dest_d;
   logic [DW-1:0]    ex_in1_q, ex_in1_d;
   logic [DW-1:0]    ex_in2_q, ex_in2_d;
   logic [DW-1:0]    rf_q [NREG];
   logic [DW-1:0]    rf_d [NREG];
   logic             wb_valid_q, wb_valid_d;
   logic [AW-1:0]    wb_dest_q, wb_dest_d;
   logic [DW-1:0]    wb_data_q, wb_data_d;
   logic [DW-1:0]    retired_q, retired_d;

   logic [OPW-1:0]   op_in;
   logic [AW-1:0]    dest_in, src_in, rd1_addr;
   logic             is_binary, ex_writes, ex_halt, accept;
   logic [DW-1:0]    rd1_data, rd2_data;

   assign op_in   = instr[15:12];
   assign dest_in = instr[11:6];
   assign src_in  = instr[5:0];

   assign ex_writes = ex_valid_q && (ex_op_q <= OP_LAST_WR);
   assign ex_halt   = ex_valid_q && (ex_op_q == OP_HALT);
   assign in_ready  = !reset && (state_q == ST_RUN) && !ex_halt;
   assign accept    = in_valid && in_ready;

   // Operand read with bypass of the result being produced in EX this cycle
   always_comb begin
      is_binary = op_in inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
      rd1_addr  = is_binary ? dest_in : src_in;
      rd1_data  = (ex_writes && (rd1_addr == ex_dest_q)) ? alu_result : rf_q[rd1_addr];
      rd2_data  = (ex_writes && (src_in == ex_dest_q))   ? alu_result : rf_q[src_in];
   end

   always_comb begin
      state_d    = state_q;
      ex_valid_d = accept;
      ex_op_d    = '0;
      ex_dest_d  = '0;
      ex_in1_d   = '0;
      ex_in2_d   = '0;
      rf_d       = rf_q;
      wb_valid_d = ex_writes;
      wb_dest_d  = wb_dest_q;
      wb_data_d  = wb_data_q;
      retired_d  = retired_q + DW'(ex_valid_q);

      if (ex_halt) state_d = ST_HALT;

      if (accept) begin
         ex_op_d   = op_in;
         ex_dest_d = dest_in;
         ex_in1_d  = rd1_data;
         ex_in2_d  = is_binary ? rd2_data : '0;
      end

      // Pipeline writeback is applied after the debug write so it wins on a collision
      if (dbg_we) rf_d[dbg_addr] = dbg_wdata;
      if (ex_writes) begin
         rf_d[ex_dest_q] = alu_result;
         wb_dest_d       = ex_dest_q;
         wb_data_d       = alu_result;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_RUN;
         ex_valid_q <= 1'b0;
         ex_op_q    <= '0;
         ex_dest_q  <= '0;
         ex_in1_q   <= '0;
         ex_in2_q   <= '0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         wb_valid_q <= 1'b0;
         wb_dest_q  <= '0;
         wb_data_q  <= '0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         ex_valid_q <= ex_valid_d;
         ex_op_q    <= ex_op_d;
         ex_dest_q  <= ex_dest_d;
         ex_in1_q   <= ex_in1_d;
         ex_in2_q   <= ex_in2_d;
         rf_q       <= rf_d;
         wb_valid_q <= wb_valid_d;
         wb_dest_q  <= wb_dest_d;
         wb_data_q  <= wb_data_d;
         retired_q  <= retired_d;
      end
   end

   // EX fields are zeroed when no instruction is held, so they drive the ALU directly
   assign alu_op    = {1'b0, ex_op_q};
   assign alu_in1   = ex_in1_q;
   assign alu_in2   = ex_in2_q;
   assign wb_valid  = wb_valid_q;
   assign wb_dest   = wb_dest_q;
   assign wb_data   = wb_data_q;
   assign dbg_rdata = rf_q[dbg_addr];
   assign halted    = (state_q == ST_HALT);
   assign retired   = retired_q;

endmodule
